// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic             accept_c, last_c;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
  logic [CW-1:0]    cnt;
  logic             br, d, bo;

  full_subtractor_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  // New difference bit enters from the MSB side.
  assign res_nx = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_c   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs; results commit only on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      busy <= (state_nx == BUSY);
      done <= (state_nx == DONE);
      if (accept_c) begin
        a_sh <= a;
        b_sh <= b;
        br   <= bin;
        res  <= '0;
        cnt  <= '0;
      end else if (state == BUSY) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        br   <= bo;
        res  <= res_nx;
        cnt  <= cnt + CW'(1);
      end
      if (last_c) begin
        diff <= res_nx;
        bout <= bo;
`ifdef SERIAL_SUB_OVF_EN
        ovf  <= br ^ bo;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Overflow checks compile in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start1, bin1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf1;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start an 8-bit op at the next negedge and follow it to done; returns in the DONE cycle.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int edges, nb;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; bin8 = ~bi;
    check({tag, "_busy_after_accept"}, 32'(busy8), 32'd1);
    check({tag, "_done_after_accept"}, 32'(done8), 32'd0);
    nb = busy8 ? 1 : 0;
    edges = 0;
    while (!done8 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (busy8) nb++;
    end
    check({tag, "_done"},  32'(done8), 32'd1);
    check({tag, "_edges"}, 32'(edges), 32'd8);
    check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
    check({tag, "_diff"}, 32'(diff8), 32'(ed));
    check({tag, "_bout"}, 32'(bout8), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x overflow argument");
`endif
  endtask

  task automatic op1(input string tag, input logic a, input logic b, input logic bi,
                     input logic ed, input logic eb);
    int edges;
    @(negedge clk);
    a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(busy1), 32'd1);
    edges = 0;
    while (!done1 && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_edges"}, 32'(edges), 32'd1);
    check({tag, "_d"},  32'(diff1), 32'(ed));
    check({tag, "_bo"}, 32'(bout1), 32'(eb));
  endtask

  // Full-subtractor truth table indexed by {a,b,bin}.
  logic [7:0] tt_d  = 8'b1001_0110;
  logic [7:0] tt_bo = 8'b1000_1110;

  initial begin
    int dcount;
    logic [2:0] idx;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      op1($sformatf("w1_%0d", i), idx[2], idx[1], idx[0], tt_d[i], tt_bo[i]);
    end

    // WIDTH=8 basic and borrow cases
    op8("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    op8("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op8("b2b_10_0F", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    op8("ovf_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    op8("ovf_7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    op8("mix_A5_3C", 8'hA5, 8'h3C, 1'b1, 8'h68, 1'b0, 1'b1);

    // start re-pulsed mid-BUSY: ignored
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dcount = 0;
    while (!done8 && dcount < 20) begin
      @(negedge clk);
      dcount++;
    end
    check("restart_done", 32'(done8), 32'd1);
    check("restart_diff", 32'(diff8), 32'h02);
    check("restart_bout", 32'(bout8), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy8), 32'd0);
    check("idle_done", 32'(done8), 32'd0);
    check("idle_diff_hold", 32'(diff8), 32'h02);

    // Reset at bit 4 of 8 aborts with no done pulse
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    op8("after_abort", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
